// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, decode and redirect signals.
// The master side is the fetch unit; the slave side is memory, decode and execute.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC ownership, credit-limited instruction reads,
// instruction buffer towards decode and redirect/flush handling.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | fetching sequentially from fetch_pc
// ST_HALT | misaligned redirect taken; no requests, in-flight data drains
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]    state;
  logic          fault;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic          req_valid;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   in_use;

  // drop_cnt never exceeds outstanding, so this cannot underflow
  assign in_use    = {1'b0, count} + {1'b0, outstanding} - {1'b0, drop_cnt};
  assign req_valid = (state == ST_RUN) && !bus.redirect_valid
                     && (outstanding < CW'(MAX_OUTSTANDING))
                     && (in_use < (CW+1)'(FIFO_DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign rsp_fire  = bus.imem_rsp_valid && (outstanding != '0);
  assign push      = rsp_fire && (drop_cnt == '0) && !bus.redirect_valid;
  assign pop       = (count != '0) && bus.instr_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = (count != '0);
  assign bus.instr          = instr_mem[head];
  assign bus.instr_pc       = pc_mem[head];
  assign bus.fetch_fault    = fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      fault       <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (bus.redirect_valid) begin
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        drop_cnt <= outstanding - CW'(rsp_fire);
        fetch_pc <= bus.redirect_pc;
        rsp_pc   <= bus.redirect_pc;
        if (bus.redirect_pc[1:0] == 2'b00) begin
          state <= ST_RUN;
          fault <= 1'b0;
        end else begin
          state <= ST_HALT;
          fault <= 1'b1;
        end
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          tail   <= tail + 1'b1;
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= bus.imem_rsp_data;
      pc_mem[tail]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam int MAXO  = 2;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic        mem_hold;
  logic        spur;
  logic [31:0] mem_q[$];

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      if (!rst && bus.imem_req_valid && bus.imem_req_ready) mem_q.push_back(bus.imem_req_addr);
      #2;
      if (rst) begin
        mem_q.delete();
        bus.imem_rsp_valid = 1'b0;
      end else if (!mem_hold && mem_q.size() > 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_q.pop_front() ^ KEY;
      end else begin
        bus.imem_rsp_valid = spur;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] d; logic [31:0] pc; } ent_t;
  ent_t        m_fifo[$];
  logic [31:0] m_fetch_pc, m_rsp_pc;
  int          m_out, m_drop;
  bit          m_halt, m_fault, m_live = 0;

  function automatic bit m_req();
    return !m_halt && !bus.redirect_valid && (m_out < MAXO)
           && (m_fifo.size() + m_out - m_drop < DEPTH);
  endfunction

  always @(posedge clk) begin
    bit acc, rsp, pop;
    acc = m_req() && bus.imem_req_ready;
    rsp = bus.imem_rsp_valid && (m_out > 0);
    pop = (m_fifo.size() != 0) && bus.instr_ready;
    if (rst) begin
      m_fifo.delete();
      m_fetch_pc = 32'h0; m_rsp_pc = 32'h0;
      m_out = 0; m_drop = 0; m_halt = 0; m_fault = 0; m_live = 1;
    end else if (m_live) begin
      m_out = m_out - int'(rsp);
      if (bus.redirect_valid) begin
        m_fifo.delete();
        m_drop     = m_out;
        m_fetch_pc = bus.redirect_pc;
        m_rsp_pc   = bus.redirect_pc;
        m_halt     = (bus.redirect_pc[1:0] != 2'b00);
        m_fault    = m_halt;
      end else begin
        if (pop) void'(m_fifo.pop_front());
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            m_fifo.push_back('{d: bus.imem_rsp_data, pc: m_rsp_pc});
            m_rsp_pc += 32'd4;
          end
        end
        if (acc) begin
          m_out++;
          m_fetch_pc += 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_live) begin
      chk("req_valid", bus.imem_req_valid, m_req());
      if (m_req()) chk("req_addr", bus.imem_req_addr, m_fetch_pc);
      chk("instr_valid", bus.instr_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) begin
        chk("instr", bus.instr, m_fifo[0].d);
        chk("instr_pc", bus.instr_pc, m_fifo[0].pc);
      end
      chk("fetch_fault", bus.fetch_fault, m_fault);
    end
  end

  logic [31:0] got[$];
  always @(posedge clk) begin
    if (!rst && bus.instr_valid && bus.instr_ready) got.push_back(bus.instr_pc);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    got.delete();
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic wait_head(input logic [31:0] pc);
    int n = 0;
    while (n < 20) begin
      cyc();
      #2;
      if (bus.instr_valid) break;
      n++;
    end
    chk("head_seen", bus.instr_valid, 1'b1);
    chk("head_pc", bus.instr_pc, pc);
    chk("head_instr", bus.instr, pc ^ KEY);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    mem_hold = 1'b0;
    spur = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    cyc();

    // sequential fetch, 1-cycle memory
    do_reset();
    #2;
    chk("rst_req_valid", bus.imem_req_valid, 1'b1);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_fault", bus.fetch_fault, 1'b0);
    cyc(); #2;
    chk("lat_n1_valid", bus.instr_valid, 1'b0);
    cyc(); #2;
    chk("lat_n2_valid", bus.instr_valid, 1'b1);
    chk("lat_n2_pc", bus.instr_pc, 32'h0);
    chk("lat_n2_instr", bus.instr, 32'hA5A5_0000);
    repeat (12) cyc();
    chk("seq_count_ok", got.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++)
      if (got.size() > i) chk("seq_pc", got[i], 32'(4 * i));

    // decode stall: buffer fills, fetching stops
    bus.instr_ready = 1'b0;
    repeat (8) cyc();
    #2;
    chk("stall_req_valid", bus.imem_req_valid, 1'b0);
    chk("stall_instr_valid", bus.instr_valid, 1'b1);
    chk("model_fill", m_fifo.size(), 2);
    chk("model_out", m_out, 0);
    cyc();
    bus.instr_ready = 1'b1;
    repeat (8) cyc();

    // memory backpressure: request held
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("hold_valid", bus.imem_req_valid, 1'b1);
      chk("hold_addr", bus.imem_req_addr, 32'h0);
      cyc();
    end
    bus.imem_req_ready = 1'b1;
    repeat (12) cyc();
    for (int i = 0; i < 3; i++)
      if (got.size() > i) chk("hold_seq_pc", got[i], 32'(4 * i));
      else chk("hold_seq_len", got.size(), i + 1);

    // redirect with one buffered and one in flight
    bus.instr_ready = 1'b0;
    do_reset();
    cyc();
    cyc();
    mem_hold = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    #2;
    chk("redir_req_valid", bus.imem_req_valid, 1'b0);
    chk("model_buf1", m_fifo.size(), 1);
    chk("model_out1", m_out, 1);
    cyc();
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    #2;
    chk("redir_flushed", bus.instr_valid, 1'b0);
    chk("redir_req_addr", bus.imem_req_addr, 32'h100);
    bus.instr_ready = 1'b1;
    wait_head(32'h100);

    // redirect with two in flight
    cyc();
    mem_hold = 1'b1;
    do_reset();
    cyc();
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h180;
    #2;
    chk("model_out2", m_out, 2);
    cyc();
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    wait_head(32'h180);

    // misaligned redirect halts, spurious response ignored, aligned redirect resumes
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    cyc();
    bus.redirect_valid = 1'b0;
    #2;
    chk("halt_fault", bus.fetch_fault, 1'b1);
    chk("halt_req_valid", bus.imem_req_valid, 1'b0);
    chk("halt_instr_valid", bus.instr_valid, 1'b0);
    repeat (4) cyc();
    spur = 1'b1;
    #2;
    chk("model_spur_out", m_out, 0);
    cyc();
    spur = 1'b0;
    #2;
    chk("spur_halt_valid", bus.instr_valid, 1'b0);
    chk("spur_halt_req", bus.imem_req_valid, 1'b0);
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    cyc();
    bus.redirect_valid = 1'b0;
    #2;
    chk("resume_fault", bus.fetch_fault, 1'b0);
    chk("resume_req_valid", bus.imem_req_valid, 1'b1);
    chk("resume_req_addr", bus.imem_req_addr, 32'h200);
    wait_head(32'h200);

    // spurious response while running but idle
    cyc();
    bus.imem_req_ready = 1'b0;
    repeat (5) cyc();
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    #2;
    chk("spur_run_valid", bus.instr_valid, 1'b0);
    cyc();
    bus.imem_req_ready = 1'b1;
    repeat (8) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
